// File: rtl/complex_result_acc.sv
// Complex dot-product accumulator on the multiplier result stream.
// Sums ACC_LEN products (or fewer on flush) and hands the sum downstream.
module complex_result_acc #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_LEN    = 4,
  parameter  int GUARD_BITS = 2,
  localparam int PW         = 2*DATA_WIDTH,
  localparam int ACC_WIDTH  = PW+GUARD_BITS,
  localparam int CNT_W      = $clog2(ACC_LEN+1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sw_rst,
  input  logic                 res_val,
  output logic                 res_ready,
  input  logic [PW-1:0]        result_re,
  input  logic [PW-1:0]        result_im,
  input  logic                 flush,
  output logic                 acc_val,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc_re,
  output logic [ACC_WIDTH-1:0] acc_im,
  output logic [CNT_W-1:0]     acc_cnt
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] sum_re;
  logic [ACC_WIDTH-1:0] sum_im;
  logic [CNT_W-1:0]     count;

  logic                 accept;
  logic                 last;
  logic                 close;
  logic [ACC_WIDTH-1:0] ext_re;
  logic [ACC_WIDTH-1:0] ext_im;
  logic [ACC_WIDTH-1:0] nsum_re;
  logic [ACC_WIDTH-1:0] nsum_im;
  logic [CNT_W-1:0]     ncnt;

  assign res_ready = (state == ACCUM);
  assign acc_val   = (state == HOLD);

  always_comb begin
    accept  = res_val & res_ready;
    ext_re  = {{GUARD_BITS{result_re[PW-1]}}, result_re};
    ext_im  = {{GUARD_BITS{result_im[PW-1]}}, result_im};
    nsum_re = sum_re;
    nsum_im = sum_im;
    ncnt    = count;
    if (accept) begin
      nsum_re = sum_re + ext_re;
      nsum_im = sum_im + ext_im;
      ncnt    = count + CNT_W'(1);
    end
    last  = (count == CNT_W'(ACC_LEN-1));
    // A beat landing in the flush cycle still counts toward the sum
    close = (accept & last) |
            (flush & ((count != '0) | accept));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ACCUM;
      sum_re  <= '0;
      sum_im  <= '0;
      count   <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      acc_cnt <= '0;
    end else if (sw_rst) begin
      state   <= ACCUM;
      sum_re  <= '0;
      sum_im  <= '0;
      count   <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      acc_cnt <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (close) begin
            state   <= HOLD;
            acc_re  <= nsum_re;
            acc_im  <= nsum_im;
            acc_cnt <= ncnt;
            sum_re  <= '0;
            sum_im  <= '0;
            count   <= '0;
          end else begin
            sum_re <= nsum_re;
            sum_im <= nsum_im;
            count  <= ncnt;
          end
        end
        HOLD: begin
          if (acc_ready) state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_result_acc.sv
// Bench for complex_result_acc: vector table plus scoreboard,
// with hand sequences for backpressure, flush and resets.
module tb_complex_result_acc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sw_rst;
  logic        res_val;
  logic        res_ready;
  logic [15:0] result_re;
  logic [15:0] result_im;
  logic        flush;
  logic        acc_val;
  logic        acc_ready;
  logic [17:0] acc_re;
  logic [17:0] acc_im;
  logic [2:0]  acc_cnt;

  complex_result_acc #(
    .DATA_WIDTH(8), .ACC_LEN(4), .GUARD_BITS(2)
  ) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst),
    .res_val(res_val), .res_ready(res_ready),
    .result_re(result_re), .result_im(result_im),
    .flush(flush), .acc_val(acc_val),
    .acc_ready(acc_ready), .acc_re(acc_re),
    .acc_im(acc_im), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] re;
    logic [17:0] im;
    logic [2:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
    logic [17:0]      er;
    logic [17:0]      ei;
  } vec_t;

  exp_t q[$];
  vec_t tbl[4];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [17:0] re,
                      input logic [17:0] im,
                      input logic [2:0] cnt);
    exp_t e;
    e.re  = re;
    e.im  = im;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  // Handshake is decided at the next posedge; sample mid-cycle
  always @(negedge clk) begin
    if (rstn && acc_val && acc_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_sum", {46'd0, acc_re}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum_re", {46'd0, acc_re}, {46'd0, e.re});
        chk("sum_im", {46'd0, acc_im}, {46'd0, e.im});
        chk("sum_cnt", {61'd0, acc_cnt}, {61'd0, e.cnt});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!res_ready && n < 20) begin
      step();
      n++;
    end
    if (!res_ready) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic beat(input logic [15:0] re,
                      input logic [15:0] im,
                      input logic fl);
    res_val   = 1'b1;
    result_re = re;
    result_im = im;
    flush     = fl;
    wait_ready();
    step();
    res_val = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    wait_ready();
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = {16'd4, 16'd3, 16'd2, 16'd1,
              16'd40, 16'd30, 16'd20, 16'd10,
              18'd10, 18'd100};
    tbl[1] = {{4{16'hFFFF}}, {4{16'h8000}},
              18'h3FFFC, 18'h20000};
    tbl[2] = {{4{16'h7FFF}}, {4{16'h0000}},
              18'h1FFFC, 18'h00000};
    tbl[3] = {16'hFFFE, 16'd2, 16'hFFFF, 16'd1,
              16'h8000, 16'd0, 16'd0, 16'd100,
              18'h00000, 18'h38064};

    rstn      = 1'b0;
    sw_rst    = 1'b0;
    res_val   = 1'b0;
    result_re = '0;
    result_im = '0;
    flush     = 1'b0;
    acc_ready = 1'b1;
    #12;
    chk("rst_ready", {63'd0, res_ready}, 64'd1);
    chk("rst_val", {63'd0, acc_val}, 64'd0);
    chk("rst_re", {46'd0, acc_re}, 64'd0);
    chk("rst_im", {46'd0, acc_im}, 64'd0);
    chk("rst_cnt", {61'd0, acc_cnt}, 64'd0);
    rstn = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      push(tbl[v].er, tbl[v].ei, 3'd4);
      for (int b = 0; b < 4; b++)
        beat(tbl[v].re[b], tbl[v].im[b], 1'b0);
      chk("val_rise", {63'd0, acc_val}, 64'd1);
      step();
      chk("val_fall", {63'd0, acc_val}, 64'd0);
      drain();
    end

    // backpressure: sum held, no beat absorbed
    acc_ready = 1'b0;
    for (int b = 0; b < 4; b++) beat(16'd3, 16'd0, 1'b0);
    push(18'd12, 18'd0, 3'd4);
    res_val   = 1'b1;
    result_re = 16'd100;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_ready", {63'd0, res_ready}, 64'd0);
      chk("hold_val", {63'd0, acc_val}, 64'd1);
      chk("hold_re", {46'd0, acc_re}, 64'd12);
    end
    res_val   = 1'b0;
    acc_ready = 1'b1;
    drain();
    push(18'd4, 18'd0, 3'd4);
    for (int b = 0; b < 4; b++) beat(16'd1, 16'd0, 1'b0);
    drain();

    // flush after two beats, then flush with nothing pending
    beat(16'd5, 16'd0, 1'b0);
    beat(16'd7, 16'd0, 1'b0);
    push(18'd12, 18'd0, 3'd2);
    do_flush();
    drain();
    do_flush();
    chk("empty_flush0", {63'd0, acc_val}, 64'd0);
    step();
    chk("empty_flush1", {63'd0, acc_val}, 64'd0);

    // flush coinciding with third beat
    beat(16'd1, 16'd0, 1'b0);
    beat(16'd1, 16'd0, 1'b0);
    push(18'd3, 18'd0, 3'd3);
    beat(16'd1, 16'd0, 1'b1);
    drain();

    // async reset mid-sum discards the partial sum
    beat(16'd9, 16'd0, 1'b0);
    beat(16'd9, 16'd0, 1'b0);
    rstn = 1'b0;
    #2;
    chk("arst_ready", {63'd0, res_ready}, 64'd1);
    rstn = 1'b1;
    push(18'd8, 18'd0, 3'd4);
    for (int b = 0; b < 4; b++) beat(16'd2, 16'd0, 1'b0);
    drain();

    // sw_rst while holding a sum
    acc_ready = 1'b0;
    for (int b = 0; b < 4; b++) beat(16'd5, 16'd0, 1'b0);
    chk("pre_swrst_re", {46'd0, acc_re}, 64'd20);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("swrst_val", {63'd0, acc_val}, 64'd0);
    chk("swrst_re", {46'd0, acc_re}, 64'd0);
    chk("swrst_ready", {63'd0, res_ready}, 64'd1);
    chk("swrst_cnt", {61'd0, acc_cnt}, 64'd0);
    acc_ready = 1'b1;
    push(18'd4, 18'd0, 3'd4);
    for (int b = 0; b < 4; b++) beat(16'd1, 16'd0, 1'b0);
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
